// File: rtl/tx_frame_arbiter_if.sv
// Handshake bundle between the two frame sources, the arbiter and the transmit path.
// master: the environment side (sources and tx sink); slave: the arbiter.
interface tx_frame_arbiter_if;
    logic       req0_pct_qued;
    logic [7:0] req0_data;
    logic       req0_valid;
    logic       req0_last;
    logic       req0_ready;
    logic       req1_pct_qued;
    logic [7:0] req1_data;
    logic       req1_valid;
    logic       req1_last;
    logic       req1_ready;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_last;
    logic       tx_src;
    logic       tx_ready;
    logic       tx_busy;
    logic       len_err;

    modport master (
        output req0_pct_qued, req0_data, req0_valid, req0_last,
        input  req0_ready,
        output req1_pct_qued, req1_data, req1_valid, req1_last,
        input  req1_ready,
        input  tx_data, tx_valid, tx_last, tx_src, tx_busy, len_err,
        output tx_ready
    );

    modport slave (
        input  req0_pct_qued, req0_data, req0_valid, req0_last,
        output req0_ready,
        input  req1_pct_qued, req1_data, req1_valid, req1_last,
        output req1_ready,
        output tx_data, tx_valid, tx_last, tx_src, tx_busy, len_err,
        input  tx_ready
    );
endinterface

// File: rtl/tx_frame_arbiter.sv
// Frame-granular round-robin arbiter for two byte-stream sources sharing one
// transmit path; enforces the inter-frame gap and truncates/drains overlong frames.
module tx_frame_arbiter #(
    parameter int unsigned IFG_CYCLES = 12,
    parameter int unsigned MAX_LEN    = 1518,
    parameter int unsigned LEN_W      = 11
) (
    input  logic              clk,
    input  logic              rst,
    tx_frame_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, XFER, DRAIN, GAP} state_t;

    localparam int unsigned GAP_W = (IFG_CYCLES > 1) ? $clog2(IFG_CYCLES) : 1;

    state_t             state, state_nxt;
    logic [LEN_W-1:0]   byte_cnt, byte_cnt_nxt;
    logic [GAP_W-1:0]   gap_cnt, gap_cnt_nxt;
    logic               grant, grant_nxt;
    logic               last_grant, last_grant_nxt;
    logic               len_err_q, len_err_nxt;

    logic [7:0]         g_data;
    logic               g_valid;
    logic               g_last;
    logic               g_ready;
    logic               at_max;

    always_comb begin
        g_data  = grant ? bus.req1_data  : bus.req0_data;
        g_valid = grant ? bus.req1_valid : bus.req0_valid;
        g_last  = grant ? bus.req1_last  : bus.req0_last;
    end

    // Next accept would be byte number MAX_LEN.
    assign at_max = (byte_cnt == LEN_W'(MAX_LEN - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            byte_cnt   <= '0;
            gap_cnt    <= '0;
            grant      <= 1'b0;
            last_grant <= 1'b1;
            len_err_q  <= 1'b0;
        end else begin
            state      <= state_nxt;
            byte_cnt   <= byte_cnt_nxt;
            gap_cnt    <= gap_cnt_nxt;
            grant      <= grant_nxt;
            last_grant <= last_grant_nxt;
            len_err_q  <= len_err_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        byte_cnt_nxt   = byte_cnt;
        gap_cnt_nxt    = gap_cnt;
        grant_nxt      = grant;
        last_grant_nxt = last_grant;
        len_err_nxt    = 1'b0;
        g_ready        = 1'b0;
        bus.tx_data    = '0;
        bus.tx_valid   = 1'b0;
        bus.tx_last    = 1'b0;

        case (state)
            IDLE: begin
                if (bus.req0_pct_qued || bus.req1_pct_qued) begin
                    // Contention goes to whichever source did not send last.
                    grant_nxt = (bus.req0_pct_qued && bus.req1_pct_qued) ? ~last_grant
                                                                         : bus.req1_pct_qued;
                    state_nxt = XFER;
                end
            end
            XFER: begin
                bus.tx_data  = g_data;
                bus.tx_valid = g_valid;
                bus.tx_last  = g_last | at_max;
                g_ready      = bus.tx_ready;
                if (g_valid && bus.tx_ready) begin
                    if (g_last) begin
                        state_nxt      = GAP;
                        last_grant_nxt = grant;
                        byte_cnt_nxt   = '0;
                    end else if (at_max) begin
                        state_nxt    = DRAIN;
                        len_err_nxt  = 1'b1;
                        byte_cnt_nxt = byte_cnt + LEN_W'(1);
                    end else begin
                        byte_cnt_nxt = byte_cnt + LEN_W'(1);
                    end
                end
            end
            DRAIN: begin
                g_ready = 1'b1;
                if (g_valid && g_last) begin
                    state_nxt      = GAP;
                    last_grant_nxt = grant;
                    byte_cnt_nxt   = '0;
                end
            end
            GAP: begin
                if (gap_cnt == GAP_W'(IFG_CYCLES - 1)) begin
                    gap_cnt_nxt = '0;
                    state_nxt   = IDLE;
                end else begin
                    gap_cnt_nxt = gap_cnt + GAP_W'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase

        bus.req0_ready = g_ready & ~grant;
        bus.req1_ready = g_ready & grant;
    end

    assign bus.tx_src  = grant;
    assign bus.tx_busy = (state != IDLE);
    assign bus.len_err = len_err_q;
endmodule

// File: tb/tb_tx_frame_arbiter.sv
// Scenario-table bench for tx_frame_arbiter: source models feed frames, a byte
// scoreboard checks forwarded data, with per-scenario gap/length/handshake checks.
module tb_tx_frame_arbiter;
    localparam int MAXL   = 1518;
    localparam int BUDGET = 6000;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    tx_frame_arbiter_if bus();

    tx_frame_arbiter #(.IFG_CYCLES(12), .MAX_LEN(MAXL), .LEN_W(11)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct { logic [7:0] data; logic last; } src_byte_t;
    typedef struct { logic [7:0] data; logic last; logic src; } exp_t;
    typedef struct {
        bit toggle;
        int len0;
        int len1;
        int nframes;
        int exp_len_err;
        int exp_drain;
        int exp_busy_after;
        int exp_gaps;
    } scen_t;

    src_byte_t src_q0[$];
    src_byte_t src_q1[$];
    exp_t      exp_q[$];

    int compared   = 0;
    int mismatched = 0;
    int cyc        = 0;
    int len_err_cnt, drain_cnt, busy_after, bad_gap, gap_seen, mirror_bad, other_ready, zero_run;
    int acc0_cnt;
    bit seen_last;

    task automatic check(input string name, input int act, input int req);
        compared++;
        if (act !== req) begin
            mismatched++;
            $display("FAIL %s: got %0d required %0d", name, act, req);
        end
    endtask

    task automatic clear_stats();
        len_err_cnt = 0; drain_cnt = 0; busy_after = 0; bad_gap = 0; gap_seen = 0;
        mirror_bad = 0; other_ready = 0; zero_run = 0; seen_last = 0; acc0_cnt = 0;
    endtask

    task automatic load_frame(input int src, input int len, input int tag);
        int fwd;
        fwd = (len > MAXL) ? MAXL : len;
        for (int i = 0; i < len; i++) begin
            src_byte_t b;
            b.data = 8'(tag * 37 + i);
            b.last = (i == len - 1);
            if (src == 0) src_q0.push_back(b); else src_q1.push_back(b);
            if (i < fwd) begin
                exp_t e;
                e.data = b.data;
                e.last = (i == fwd - 1);
                e.src  = (src != 0);
                exp_q.push_back(e);
            end
        end
    endtask

    task automatic drive_inputs(input bit toggle);
        bus.req0_pct_qued = (src_q0.size() != 0);
        bus.req0_valid    = (src_q0.size() != 0);
        bus.req0_data     = (src_q0.size() != 0) ? src_q0[0].data : 8'h00;
        bus.req0_last     = (src_q0.size() != 0) ? src_q0[0].last : 1'b0;
        bus.req1_pct_qued = (src_q1.size() != 0);
        bus.req1_valid    = (src_q1.size() != 0);
        bus.req1_data     = (src_q1.size() != 0) ? src_q1[0].data : 8'h00;
        bus.req1_last     = (src_q1.size() != 0) ? src_q1[0].last : 1'b0;
        bus.tx_ready      = toggle ? cyc[0] : 1'b1;
    endtask

    task automatic check_outputs_zero(input string name);
        check(name, int'({bus.req0_ready, bus.req1_ready, bus.tx_valid, bus.tx_last,
                          bus.tx_src, bus.tx_busy, bus.len_err, bus.tx_data}), 0);
    endtask

    // One cycle: drive at negedge, sample #1 later, account for handshakes.
    task automatic step(input bit toggle, input bit check_en);
        bit acc0, acc1, tx_acc;
        exp_t e;
        @(negedge clk);
        cyc++;
        drive_inputs(toggle);
        #1;
        acc0   = bus.req0_valid & bus.req0_ready;
        acc1   = bus.req1_valid & bus.req1_ready;
        tx_acc = bus.tx_valid & bus.tx_ready;
        if (bus.len_err) len_err_cnt++;
        if ((acc0 || acc1) && !bus.tx_valid) drain_cnt++;
        if (exp_q.size() != 0) begin
            e = exp_q[0];
            if (bus.tx_valid && ((e.src ? bus.req1_ready : bus.req0_ready) != bus.tx_ready))
                mirror_bad++;
            if (e.src ? bus.req0_ready : bus.req1_ready) other_ready++;
        end
        if (bus.tx_valid) begin
            if (seen_last) begin
                gap_seen++;
                if (zero_run != 13) bad_gap++;
            end
            seen_last = 0;
            zero_run  = 0;
        end else begin
            zero_run++;
            if (seen_last && bus.tx_busy) busy_after++;
        end
        if (tx_acc && check_en) begin
            if (exp_q.size() == 0) begin
                check("unexpected_byte", 1, 0);
            end else begin
                e = exp_q.pop_front();
                check("byte", int'({bus.tx_src, bus.tx_last, bus.tx_data}),
                      int'({e.src, e.last, e.data}));
            end
        end
        if (tx_acc && bus.tx_last) seen_last = 1;
        if (acc0) begin void'(src_q0.pop_front()); acc0_cnt++; end
        if (acc1) void'(src_q1.pop_front());
    endtask

    task automatic run_until_done(input bit toggle);
        int n;
        n = 0;
        while ((src_q0.size() != 0 || src_q1.size() != 0 || exp_q.size() != 0 || bus.tx_busy)
               && n < BUDGET) begin
            step(toggle, 1'b1);
            n++;
        end
        check("done_in_budget", int'(n < BUDGET), 1);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        src_q0.delete();
        src_q1.delete();
        exp_q.delete();
        drive_inputs(1'b0);
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_outputs_zero("reset_outputs");
        @(negedge clk);
        rst = 1'b1;
        clear_stats();
    endtask

    scen_t scen[7];

    initial begin
        scen[0] = '{0, 64,   0,    1, 0, 0, 12, 0};
        scen[1] = '{0, 10,   10,   2, 0, 0, -1, 3};
        scen[2] = '{1, 100,  0,    1, 0, 0, 12, 0};
        scen[3] = '{0, 0,    1520, 1, 1, 2, 14, 0};
        scen[4] = '{0, 1518, 0,    1, 0, 0, 12, 0};
        scen[5] = '{0, 1,    1,    1, 0, 0, -1, 1};
        scen[6] = '{1, 1519, 0,    1, 1, 1, 13, 0};

        rst = 1'b1;
        drive_inputs(1'b0);
        #2 rst = 1'b0;

        for (int s = 0; s < 7; s++) begin
            apply_reset();
            for (int k = 0; k < scen[s].nframes; k++) begin
                if (scen[s].len0 > 0) load_frame(0, scen[s].len0, 2 * k + s);
                if (scen[s].len1 > 0) load_frame(1, scen[s].len1, 2 * k + s + 1);
            end
            run_until_done(scen[s].toggle);
            check($sformatf("s%0d_len_err", s), len_err_cnt, scen[s].exp_len_err);
            check($sformatf("s%0d_drain", s), drain_cnt, scen[s].exp_drain);
            if (scen[s].exp_busy_after >= 0)
                check($sformatf("s%0d_gap_busy", s), busy_after, scen[s].exp_busy_after);
            check($sformatf("s%0d_gap_count", s), gap_seen, scen[s].exp_gaps);
            check($sformatf("s%0d_bad_gaps", s), bad_gap, 0);
            check($sformatf("s%0d_ready_mirror", s), mirror_bad, 0);
            check($sformatf("s%0d_other_ready", s), other_ready, 0);
        end

        // Reset asserted mid-frame while both sources are queued.
        apply_reset();
        load_frame(0, 60, 40);
        load_frame(1, 60, 41);
        for (int n = 0; n < 200 && acc0_cnt < 29; n++) step(1'b0, 1'b0);
        check("reached_byte30", acc0_cnt, 29);
        check("busy_before_reset", int'(bus.tx_busy), 1);
        check("valid_before_reset", int'(bus.tx_valid), 1);
        #2 rst = 1'b0;
        #1 check_outputs_zero("async_reset_outputs");
        @(posedge clk);
        @(negedge clk);
        src_q0.delete();
        src_q1.delete();
        exp_q.delete();
        clear_stats();
        load_frame(0, 20, 50);
        load_frame(1, 20, 51);
        drive_inputs(1'b0);
        rst = 1'b1;
        #1 check("grant_cycle_valid", int'(bus.tx_valid), 0);
        step(1'b0, 1'b1);
        check("first_valid_src0", int'({bus.tx_valid, bus.tx_src}), 2);
        run_until_done(1'b0);
        check("post_reset_gaps", gap_seen, 1);
        check("post_reset_bad_gaps", bad_gap, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/tx_frame_arbiter.md
Name: tx_frame_arbiter

Overview:
Frame-granular round-robin arbiter that shares the single Ethernet transmit path between two frame sources. Each source is a buffered byte stream with a packet-queued flag. The arbiter grants one source per frame and forwards its bytes to the transmit datapath through a valid/ready handshake. It enforces the inter-frame gap, and truncates and drains any frame that exceeds the maximum length.

Parameters:
IFG_CYCLES, 12, idle cycles inserted after every frame end (tx_last or drain end)
MAX_LEN, 1518, maximum bytes forwarded per frame
LEN_W, 11, byte counter width; must satisfy 2^LEN_W > MAX_LEN

Ports:
clk  in  1  single clock for all logic
rst  in  1  asynchronous active-low reset
req0_pct_qued  in  1  source 0 holds at least one complete frame
req0_data  in  8  source 0 byte
req0_valid  in  1  source 0 byte valid
req0_last  in  1  source 0 final byte of frame
req0_ready  out  1  source 0 byte accepted when req0_valid & req0_ready
req1_pct_qued  in  1  source 1 holds at least one complete frame
req1_data  in  8  source 1 byte
req1_valid  in  1  source 1 byte valid
req1_last  in  1  source 1 final byte of frame
req1_ready  out  1  source 1 byte accepted when req1_valid & req1_ready
tx_data  out  8  byte to transmit path
tx_valid  out  1  tx_data valid
tx_last  out  1  final byte of forwarded frame
tx_src  out  1  index of granted source
tx_ready  in  1  transmit path accepts byte
tx_busy  out  1  arbiter not in IDLE
len_err  out  1  one-cycle pulse on length truncation

Behaviour:
- Reset (rst=0, async): state=IDLE, byte_cnt=0, gap_cnt=0, grant=0, last_grant=1 (so source 0 wins first). All outputs are 0 immediately, including when reset is asserted mid-frame. A partial frame is not resumed after reset.
- States: IDLE, XFER, DRAIN, GAP.
- IDLE:
  - Both reqN_ready=0 and tx_valid=0.
  - If either pct_qued=1: grant is registered and state goes to XFER on the next edge. This is 1 cycle of grant latency.
  - Selection: if only one source is requesting, grant that one. If both are requesting, grant the source that is not last_grant.
  - tx_src is updated with the grant and held until the next grant.
- XFER, combinational pass-through for the granted source only:
  - tx_data=reqG_data, tx_valid=reqG_valid, tx_last=reqG_last, reqG_ready=tx_ready.
  - The non-granted source's ready=0.
  - byte_cnt increments on each accept (valid & ready).
  - Accept with reqG_last=1 at byte_cnt+1 <= MAX_LEN: go to GAP, set last_grant=grant, clear byte_cnt.
  - Accept of byte number MAX_LEN with reqG_last=0:
    - Force tx_last=1 on that byte.
    - Pulse len_err for the cycle after the accept.
    - Go to DRAIN.
- DRAIN:
  - tx_valid=0, reqG_ready=1.
  - Bytes are discarded until a byte with reqG_last=1 is accepted. Then go to GAP, set last_grant=grant, clear byte_cnt.
- GAP:
  - All ready signals and tx_valid are 0.
  - gap_cnt counts 0..IFG_CYCLES-1. On the terminal count, clear gap_cnt and go to IDLE.
  - Earliest next tx_valid is IFG_CYCLES+1 cycles after the last accepted byte (GAP, then the IDLE grant cycle).
- Outside XFER, tx_data=0 and tx_last=0.
- tx_busy = (state != IDLE).
- pct_qued changes during XFER, DRAIN or GAP are ignored. Arbitration samples pct_qued only in IDLE.
- tx_ready=0 stalls XFER indefinitely with no timeout. byte_cnt is unchanged while stalled.
- byte_cnt never wraps: it cannot exceed MAX_LEN because of the truncation rule.
- A single-byte frame (last on the first byte) is legal: one accept, then GAP.

Test Plan:
1. Only req0_pct_qued=1, 64-byte frame, tx_ready=1:
   - tx_valid high for 64 consecutive cycles, tx_src=0, tx_last on byte 64.
   - Exactly 12 GAP cycles with tx_busy=1, then tx_busy=0.
   - len_err never asserted.
2. Both pct_qued held at 1 after reset, 10-byte frames:
   - Grant order is 0, 1, 0, 1.
   - Each frame is separated by 13 cycles of tx_valid=0.
3. 100-byte frame with tx_ready toggling every cycle:
   - 100 distinct bytes received in order, none lost or duplicated.
   - req0_ready mirrors tx_ready cycle-for-cycle.
   - req1_ready stays 0.
4. 1520-byte frame from source 1:
   - 1518 bytes forwarded, tx_last on byte 1518.
   - len_err high for exactly 1 cycle.
   - 2 trailing bytes consumed with tx_valid=0, then GAP.
5. 1518-byte frame with last on byte 1518:
   - Normal completion, len_err=0.
6. Both sources queued and rst driven low at byte 30 of a frame:
   - All outputs go to 0 immediately, asynchronously.
   - After rst returns high with both requests asserted, source 0 is granted first, tx_valid on the second cycle.
